// File: rtl/ex_stage_mc.sv
// MIPS execute stage with forwarding, ALU, branch-target adder and an iterative
// multiply/divide unit that owns HI/LO and stalls the pipe while it runs.
//
// state | meaning
// IDLE  | normal single-cycle execute; a mult/div start launches RUN
// RUN   | one shift-add or restoring-subtract step per cycle; outputs are bubbles
module ex_stage_mc #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_BITS  = 5,
   parameter int EXEC_BUS_WIDTH = 12,
   parameter int MEM_BUS_WIDTH  = 3,
   parameter int WB_BUS_WIDTH   = 2,
   parameter int FW_SEL_WIDTH   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [EXEC_BUS_WIDTH-1:0] execute_bus_in,
   input  logic [MEM_BUS_WIDTH-1:0]  memory_bus_in,
   input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
   input  logic [DATA_WIDTH-1:0]     reg_rs_data_in,
   input  logic [DATA_WIDTH-1:0]     reg_rs_data_from_mem_in,
   input  logic [DATA_WIDTH-1:0]     reg_rs_data_from_wb_in,
   input  logic [DATA_WIDTH-1:0]     reg_rt_data_in,
   input  logic [DATA_WIDTH-1:0]     reg_rt_data_from_mem_in,
   input  logic [DATA_WIDTH-1:0]     reg_rt_data_from_wb_in,
   input  logic [FW_SEL_WIDTH-1:0]   fw_mux_rs_select,
   input  logic [FW_SEL_WIDTH-1:0]   fw_mux_rt_select,
   input  logic [DATA_WIDTH-1:0]     inmediate_data_in,
   input  logic [DATA_WIDTH-1:0]     shamt_data_in,
   input  logic [REG_ADDR_BITS-1:0]  add_reg_rd_in,
   input  logic [REG_ADDR_BITS-1:0]  add_reg_rt_in,
   input  logic [DATA_WIDTH-1:0]     next_pc_in,
   input  logic                      flush_in,
   output logic [DATA_WIDTH-1:0]     alu_result_out,
   output logic [DATA_WIDTH-1:0]     reg_rt_data_out,
   output logic [DATA_WIDTH-1:0]     next_pc_out,
   output logic [REG_ADDR_BITS-1:0]  add_reg_w_out,
   output logic [MEM_BUS_WIDTH-1:0]  memory_bus_out,
   output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
   output logic                      alu_zero_flag_out,
   output logic                      busy_out,
   output logic [DATA_WIDTH-1:0]     hi_out,
   output logic [DATA_WIDTH-1:0]     lo_out
);
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int CW  = $clog2(DATA_WIDTH + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   logic [3:0] alu_opcode;
   logic       alu_src, reg_dst, shamt_flag, mc_start, hilo_read, hilo_sel;
   logic [1:0] mc_op;
   assign alu_opcode = execute_bus_in[3:0];
   assign alu_src    = execute_bus_in[4];
   assign reg_dst    = execute_bus_in[5];
   assign shamt_flag = execute_bus_in[6];
   assign mc_start   = execute_bus_in[7];
   assign mc_op      = execute_bus_in[9:8];
   assign hilo_read  = execute_bus_in[10];
   assign hilo_sel   = execute_bus_in[11];

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d, hi_q, hi_d, lo_q, lo_d;
   logic                      div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d, reg_rt_data_q, reg_rt_data_d;
   logic [DATA_WIDTH-1:0]     next_pc_q, next_pc_d;
   logic [REG_ADDR_BITS-1:0]  add_reg_w_q, add_reg_w_d;
   logic [MEM_BUS_WIDTH-1:0]  memory_bus_q, memory_bus_d;
   logic [WB_BUS_WIDTH-1:0]   wb_bus_q, wb_bus_d;
   logic                      alu_zero_q, alu_zero_d;

   logic [DATA_WIDTH-1:0]     rs_fw, rt_fw, alu_a, alu_b, alu_res;

   always_comb begin
      case (fw_mux_rs_select)
         2'b00:   rs_fw = reg_rs_data_in;
         2'b01:   rs_fw = reg_rs_data_from_mem_in;
         2'b10:   rs_fw = reg_rs_data_from_wb_in;
         default: rs_fw = '0;
      endcase
      case (fw_mux_rt_select)
         2'b00:   rt_fw = reg_rt_data_in;
         2'b01:   rt_fw = reg_rt_data_from_mem_in;
         2'b10:   rt_fw = reg_rt_data_from_wb_in;
         default: rt_fw = '0;
      endcase
   end

   // Shifts take the value to shift in A and the amount in B.
   always_comb begin
      if (shamt_flag) begin
         alu_a = alu_src ? inmediate_data_in : rt_fw;
         alu_b = shamt_data_in;
      end else begin
         alu_a = rs_fw;
         alu_b = alu_src ? inmediate_data_in : rt_fw;
      end
   end

   always_comb begin
      case (alu_opcode)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0001: alu_res = alu_a | alu_b;
         4'b0010: alu_res = alu_a + alu_b;
         4'b0011: alu_res = alu_a ^ alu_b;
         4'b0100: alu_res = ~(alu_a | alu_b);
         4'b0110: alu_res = alu_a - alu_b;
         4'b0111: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
         4'b1000: alu_res = alu_a << alu_b[SHW-1:0];
         4'b1001: alu_res = alu_a >> alu_b[SHW-1:0];
         4'b1010: alu_res = $signed(alu_a) >>> alu_b[SHW-1:0];
         4'b1011: alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_a < alu_b};
         default: alu_res = '0;
      endcase
   end

   logic bubble;
   assign bubble = flush_in | (state_q == S_RUN) | mc_start;

   always_comb begin
      alu_result_d  = '0;
      reg_rt_data_d = '0;
      next_pc_d     = '0;
      add_reg_w_d   = '0;
      memory_bus_d  = '0;
      wb_bus_d      = '0;
      alu_zero_d    = 1'b0;
      if (!bubble) begin
         alu_result_d  = hilo_read ? (hilo_sel ? hi_q : lo_q) : alu_res;
         reg_rt_data_d = rt_fw;
         next_pc_d     = next_pc_in + (inmediate_data_in << 2);
         add_reg_w_d   = reg_dst ? add_reg_rd_in : add_reg_rt_in;
         memory_bus_d  = memory_bus_in;
         wb_bus_d      = wb_bus_in;
         alu_zero_d    = (alu_res == '0);
      end
   end

   logic [DATA_WIDTH:0]       mul_sum, rem_sh;
   logic                      rem_ge, sgn_a, sgn_b;
   logic [DATA_WIDTH-1:0]     acc_n, a_n;
   logic [2*DATA_WIDTH-1:0]   prod;

   // a_q holds multiplier/quotient, acc_q the partial product high half/remainder.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      div_d     = div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      sgn_a     = mc_op[0] & rs_fw[DATA_WIDTH-1];
      sgn_b     = mc_op[0] & rt_fw[DATA_WIDTH-1];
      mul_sum   = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : '0);
      rem_sh    = {acc_q, a_q[DATA_WIDTH-1]};
      rem_ge    = rem_sh >= {1'b0, b_q};
      if (div_q) begin
         acc_n = rem_ge ? (rem_sh[DATA_WIDTH-1:0] - b_q) : rem_sh[DATA_WIDTH-1:0];
         a_n   = {a_q[DATA_WIDTH-2:0], rem_ge};
      end else begin
         acc_n = mul_sum[DATA_WIDTH:1];
         a_n   = {mul_sum[0], a_q[DATA_WIDTH-1:1]};
      end
      prod = neg_q ? -{acc_n, a_n} : {acc_n, a_n};
      case (state_q)
         S_IDLE: begin
            if (mc_start && !flush_in) begin
               state_d   = S_RUN;
               cnt_d     = CW'(DATA_WIDTH);
               div_d     = mc_op[1];
               a_d       = sgn_a ? -rs_fw : rs_fw;
               b_d       = sgn_b ? -rt_fw : rt_fw;
               acc_d     = '0;
               neg_d     = sgn_a ^ sgn_b;
               neg_rem_d = sgn_a;
            end
         end
         default: begin
            a_d   = a_n;
            acc_d = acc_n;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               if (div_q) begin
                  // A zero divisor leaves the full dividend in the remainder.
                  lo_d = (b_q == '0) ? '1 : (neg_q ? -a_n : a_n);
                  hi_d = neg_rem_q ? -acc_n : acc_n;
               end else begin
                  hi_d = prod[2*DATA_WIDTH-1:DATA_WIDTH];
                  lo_d = prod[DATA_WIDTH-1:0];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         acc_q         <= '0;
         div_q         <= 1'b0;
         neg_q         <= 1'b0;
         neg_rem_q     <= 1'b0;
         hi_q          <= '0;
         lo_q          <= '0;
         alu_result_q  <= '0;
         reg_rt_data_q <= '0;
         next_pc_q     <= '0;
         add_reg_w_q   <= '0;
         memory_bus_q  <= '0;
         wb_bus_q      <= '0;
         alu_zero_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         a_q           <= a_d;
         b_q           <= b_d;
         acc_q         <= acc_d;
         div_q         <= div_d;
         neg_q         <= neg_d;
         neg_rem_q     <= neg_rem_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         alu_result_q  <= alu_result_d;
         reg_rt_data_q <= reg_rt_data_d;
         next_pc_q     <= next_pc_d;
         add_reg_w_q   <= add_reg_w_d;
         memory_bus_q  <= memory_bus_d;
         wb_bus_q      <= wb_bus_d;
         alu_zero_q    <= alu_zero_d;
      end
   end

   assign alu_result_out    = alu_result_q;
   assign reg_rt_data_out   = reg_rt_data_q;
   assign next_pc_out       = next_pc_q;
   assign add_reg_w_out     = add_reg_w_q;
   assign memory_bus_out    = memory_bus_q;
   assign wb_bus_out        = wb_bus_q;
   assign alu_zero_flag_out = alu_zero_q;
   assign busy_out          = (state_q == S_RUN);
   assign hi_out            = hi_q;
   assign lo_out            = lo_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed-vector bench for ex_stage_mc: forwarding, ALU paths, branch target,
// flush, multiply/divide results, HI/LO read-after-stall and mid-operation reset.
module tb_ex_stage_mc;
   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] execute_bus_in;
   logic [2:0]  memory_bus_in;
   logic [1:0]  wb_bus_in;
   logic [31:0] rs_in, rs_mem, rs_wb, rt_in, rt_mem, rt_wb;
   logic [1:0]  rs_sel, rt_sel;
   logic [31:0] imm, shamt, next_pc_in;
   logic [4:0]  rd_addr, rt_addr;
   logic        flush_in;
   logic [31:0] alu_result_out, reg_rt_data_out, next_pc_out, hi_out, lo_out;
   logic [4:0]  add_reg_w_out;
   logic [2:0]  memory_bus_out;
   logic [1:0]  wb_bus_out;
   logic        alu_zero_flag_out, busy_out;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [11:0] MC_START = 12'h080;
   localparam logic [11:0] MFHI     = 12'hC00;
   localparam logic [11:0] MFLO     = 12'h400;

   ex_stage_mc dut (
      .clk(clk), .reset(reset),
      .execute_bus_in(execute_bus_in), .memory_bus_in(memory_bus_in), .wb_bus_in(wb_bus_in),
      .reg_rs_data_in(rs_in), .reg_rs_data_from_mem_in(rs_mem), .reg_rs_data_from_wb_in(rs_wb),
      .reg_rt_data_in(rt_in), .reg_rt_data_from_mem_in(rt_mem), .reg_rt_data_from_wb_in(rt_wb),
      .fw_mux_rs_select(rs_sel), .fw_mux_rt_select(rt_sel),
      .inmediate_data_in(imm), .shamt_data_in(shamt),
      .add_reg_rd_in(rd_addr), .add_reg_rt_in(rt_addr),
      .next_pc_in(next_pc_in), .flush_in(flush_in),
      .alu_result_out(alu_result_out), .reg_rt_data_out(reg_rt_data_out),
      .next_pc_out(next_pc_out), .add_reg_w_out(add_reg_w_out),
      .memory_bus_out(memory_bus_out), .wb_bus_out(wb_bus_out),
      .alu_zero_flag_out(alu_zero_flag_out), .busy_out(busy_out),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      execute_bus_in = '0; memory_bus_in = '0; wb_bus_in = '0;
      rs_in = '0; rs_mem = '0; rs_wb = '0; rt_in = '0; rt_mem = '0; rt_wb = '0;
      rs_sel = '0; rt_sel = '0; imm = '0; shamt = '0; next_pc_in = '0;
      rd_addr = '0; rt_addr = '0; flush_in = 1'b0;
   endtask

   // Launch a mult/div, hold `held` at the inputs, and check busy length and HI/LO.
   task automatic run_mc(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [11:0] held,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int  busy_cnt;
      logic wb_seen;
      execute_bus_in = MC_START | {2'b00, op, 8'h00};
      rs_in = a; rt_in = b; rs_sel = 2'b00; rt_sel = 2'b00;
      wb_bus_in = 2'b11; memory_bus_in = 3'b111;
      step();
      execute_bus_in = held;
      wb_bus_in = 2'b01;
      busy_cnt = 0;
      wb_seen = (wb_bus_out != 2'b00);
      while (busy_out && busy_cnt < 40) begin
         busy_cnt++;
         if (wb_bus_out != 2'b00) wb_seen = 1'b1;
         step();
      end
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      chk({tag, "_wb_bubble"}, 64'(wb_seen), 64'd0);
      chk({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      execute_bus_in = 12'h022; rs_in = 32'h1234; wb_bus_in = 2'b11; memory_bus_in = 3'b101;
      step(); step();
      chk("rst_alu", 64'(alu_result_out), 64'd0);
      chk("rst_wb", 64'(wb_bus_out), 64'd0);
      chk("rst_busy", 64'(busy_out), 64'd0);
      chk("rst_hilo", {hi_out, lo_out}, 64'd0);
      reset = 1'b1;

      // ADD, rt forwarded from mem, branch target with negative immediate
      idle_inputs();
      execute_bus_in = 12'h022; rs_in = 32'hA; rt_sel = 2'b01; rt_mem = 32'hA5A5A5A5;
      next_pc_in = 32'h100; imm = 32'hFFFFFFFF; rd_addr = 5'd7; rt_addr = 5'd9;
      memory_bus_in = 3'b101; wb_bus_in = 2'b11;
      step();
      chk("add_result", 64'(alu_result_out), 64'hA5A5A5AF);
      chk("fw_rt_mem", 64'(reg_rt_data_out), 64'hA5A5A5A5);
      chk("branch_tgt", 64'(next_pc_out), 64'hFC);
      chk("wr_addr_rd", 64'(add_reg_w_out), 64'd7);
      chk("mem_pass", 64'(memory_bus_out), 64'd5);
      chk("wb_pass", 64'(wb_bus_out), 64'd3);
      chk("zero_clr", 64'(alu_zero_flag_out), 64'd0);

      // SUB of two zero-selected operands
      execute_bus_in = 12'h006; rs_sel = 2'b11; rt_sel = 2'b11; rs_in = 32'h55;
      step();
      chk("fw_rt_zero", 64'(reg_rt_data_out), 64'd0);
      chk("zero_set", 64'(alu_zero_flag_out), 64'd1);
      chk("wr_addr_rt", 64'(add_reg_w_out), 64'd9);

      // SLL: rt from wb shifted by shamt
      execute_bus_in = 12'h048; rt_sel = 2'b10; rt_wb = 32'h3; shamt = 32'd4; rs_sel = 2'b00;
      step();
      chk("sll", 64'(alu_result_out), 64'h30);

      // OR with immediate
      execute_bus_in = 12'h011; rs_in = 32'hF0; imm = 32'h0F;
      step();
      chk("or_imm", 64'(alu_result_out), 64'hFF);

      // flush forces a bubble
      flush_in = 1'b1;
      step();
      chk("flush_wb", 64'(wb_bus_out), 64'd0);
      chk("flush_alu", 64'(alu_result_out), 64'd0);
      idle_inputs();

      run_mc("multu", 2'b00, 32'hFFFFFFFF, 32'h2, 12'h000, 32'h1, 32'hFFFFFFFE);
      step();

      // MULT with an MFHI held behind it
      run_mc("mult", 2'b01, 32'hFFFFFFFD, 32'd5, MFHI, 32'hFFFFFFFF, 32'hFFFFFFF1);
      chk("mfhi_bubble", 64'(alu_result_out), 64'd0);
      step();
      chk("mfhi_new", 64'(alu_result_out), 64'hFFFFFFFF);
      chk("mfhi_wb", 64'(wb_bus_out), 64'd1);
      execute_bus_in = MFLO;
      step();
      chk("mflo_new", 64'(alu_result_out), 64'hFFFFFFF1);

      run_mc("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 12'h000, 32'hFFFFFFFF, 32'hFFFFFFFD);
      step();
      run_mc("divu_zero", 2'b10, 32'd7, 32'd0, 12'h000, 32'h7, 32'hFFFFFFFF);
      step();
      run_mc("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 12'h000, 32'h0, 32'h80000000);
      step();
      run_mc("divu", 2'b10, 32'd100, 32'd7, 12'h000, 32'd2, 32'd14);
      step();
      run_mc("multu_b", 2'b00, 32'h12345678, 32'h10, 12'h000, 32'h1, 32'h23456780);
      step();

      // reset 10 cycles into a DIV
      execute_bus_in = MC_START | 12'h300; rs_in = 32'd100; rt_in = 32'd7;
      wb_bus_in = 2'b11; memory_bus_in = 3'b111;
      step();
      execute_bus_in = 12'h022;
      for (int i = 0; i < 10; i++) step();
      chk("mid_busy", 64'(busy_out), 64'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mrst_busy", 64'(busy_out), 64'd0);
      chk("mrst_hilo", {hi_out, lo_out}, 64'd0);
      chk("mrst_outs", {alu_result_out, reg_rt_data_out}, 64'd0);
      chk("mrst_ctl", {next_pc_out, 27'd0, add_reg_w_out}, 64'd0);
      chk("mrst_bus", {59'd0, memory_bus_out, wb_bus_out}, 64'd0);
      idle_inputs();
      run_mc("multu_post", 2'b00, 32'hFFFFFFFF, 32'h2, 12'h000, 32'h1, 32'hFFFFFFFE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
